uart_port_responder: RTL and testbench
======================================

// Module: uart_port_responder
// PURPOSE
//  Responder at the far end of the memory controller's serial-port interface:
//  the byte-wide UART that sits on the low byte of the shared RAM1 data bus.
//  Answers rdn/wrn strobes, reports tbre/tsre/data_ready, and serializes and
//  deserializes 8N1 frames on txd/rxd. Replaces the external UART chip in
//  simulation and FPGA-only builds.
// PARAMETERS
//  CLKS_PER_BIT  96  CLK cycles per serial bit (11.0592 MHz / 115200); must be >= 4
// PORTS
//  CLK         in     1  system clock; all state changes on posedge
//  RST         in     1  synchronous reset, active-high
//  rdn         in     1  read strobe, active-low, from memory controller
//  wrn         in     1  write strobe, active-low, from memory controller
//  ram1Data    inout  8  low byte of shared data bus
//  tbre        out    1  1 = transmit holding register (THR) empty
//  tsre        out    1  1 = transmit shift register idle
//  data_ready  out    1  1 = receive buffer register (RBR) holds an unread byte
//  txd         out    1  serial out; idle high
//  rxd         in     1  serial in; asynchronous, idle high
// BEHAVIOUR
//  Reset: tbre=1, tsre=1, data_ready=0, txd=1, THR/RBR=0, TX and RX FSMs in IDLE,
//   ram1Data released (Z) while RST=1.
//  Strobes: rdn, wrn, rxd pass through 2-FF synchronizers (reset to 1).
//   Edges are detected on the synchronized signals. Strobes must stay low >= 3 CLK.
//  Bus drive: ram1Data = RBR when raw rdn=0 and RST=0, else Z. This is
//   combinational so data is valid within the strobe.
//  Write: while synced wrn=0, ram1Data is sampled every CLK. On the synced wrn
//   rising edge, THR <= last sample and tbre <= 0.
//   If tbre was already 0, the write is dropped and THR is unchanged.
//  Read: on the synced rdn rising edge, data_ready <= 0.
//   If an RX frame completes in the same cycle, the new byte wins: RBR loads and
//   data_ready stays 1.
//  TX FSM IDLE->START->DATA->STOP->IDLE. Bit counter 0..7; baud counter
//   0..CLKS_PER_BIT-1.
//   IDLE: when tbre=0, load TSR <= THR, tbre <= 1, tsre <= 0, go to START
//    (1 CLK after the THR load).
//   START: txd=0 for CLKS_PER_BIT clocks.
//   DATA: txd=TSR[bit], LSB first, CLKS_PER_BIT clocks each.
//   STOP: txd=1 for CLKS_PER_BIT clocks. If tbre=0, reload back-to-back into
//    START with no idle gap (tsre stays 0); otherwise tsre <= 1, go to IDLE.
//   A write during START/DATA/STOP fills THR without disturbing the frame.
//  RX FSM IDLE->START->DATA->STOP->IDLE:
//   IDLE: synced rxd falls -> START, baud counter cleared.
//   START: at CLKS_PER_BIT/2, if rxd=1 it was a glitch -> IDLE; else -> DATA.
//   DATA: sample each bit at its mid-point (every CLKS_PER_BIT from the start
//    mid-point), LSB first, into a shift register.
//   STOP: sample at mid-point. rxd=1 -> RBR <= shift reg, data_ready <= 1.
//    rxd=0 is a framing error: byte discarded, flags unchanged. Then IDLE.
//   Overrun (data_ready=1 on completion): RBR overwritten, data_ready stays 1.
//  TX and RX are independent and may run simultaneously.
//  RST mid-frame: all outputs return to reset values on the next posedge; the
//   partial frame is abandoned and txd goes high immediately.
// TESTING (CLKS_PER_BIT=16)
//  1 write 0xA5 via wrn low 4 CLK -> tbre 0 then 1; txd = 0,1,0,1,0,0,1,0,1,1,
//    16 CLK per bit; tsre=1 after stop.
//  2 two writes 0x01,0x80 back-to-back -> frames contiguous, no idle bit;
//    third write while tbre=0 dropped.
//  3 drive rxd with 8N1 0x3C -> data_ready=1, RBR=0x3C; rdn low ->
//    ram1Data=0x3C; rdn rising -> data_ready=0.
//  4 rxd 4-CLK low glitch -> no byte, data_ready stays 0;
//    stop bit forced 0 -> byte discarded.
//  5 second RX frame 0x55 completes on the same cycle as the rdn rising
//    edge -> RBR=0x55, data_ready=1.
//  6 RST asserted mid-TX at bit 3 -> next CLK: txd=1, tbre=1, tsre=1;
//    ram1Data Z with rdn=0.

Source files
------------

// File: rtl/uart_port_responder_if.sv
// Strobe and status bundle between the memory controller and the UART
// responder. The shared ram1Data bus stays a plain inout on the responder
// so the tristate resolution happens at a module port.
interface uart_port_responder_if;
  logic rdn;         // read strobe, active-low
  logic wrn;         // write strobe, active-low
  logic tbre;        // 1 = transmit holding register empty
  logic tsre;        // 1 = transmit shift register idle
  logic data_ready;  // 1 = receive buffer holds an unread byte

  modport master (output rdn, wrn, input tbre, tsre, data_ready);
  modport slave  (input rdn, wrn, output tbre, tsre, data_ready);
endinterface

// File: rtl/uart_port_responder.sv
// Byte-wide 8N1 UART responder on the low byte of the RAM1 data bus.
// Stands in for the external UART chip: answers rdn/wrn strobes, reports
// tbre/tsre/data_ready, and serializes/deserializes frames on txd/rxd.
module uart_port_responder #(
  parameter int CLKS_PER_BIT = 96   // CLK cycles per serial bit, >= 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_port_responder_if.slave  bus,
  inout  wire  [7:0]            ram1Data,
  output logic                  txd,
  input  logic                  rxd
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // synchronizer stages plus one extra flop each for edge detection
  logic rdn_s1_q, rdn_s2_q, rdn_p_q;
  logic wrn_s1_q, wrn_s2_q, wrn_p_q;
  logic rxd_s1_q, rxd_s2_q, rxd_p_q;
  logic rdn_rise, wrn_rise, rxd_fall;

  // transmit side
  state_t          tx_state_q;
  logic [BW-1:0]   tx_baud_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      thr_q, tsr_q, wr_smp_q;
  logic            tbre_q, tsre_q, txd_q;
  logic [2:0]      tx_bit_d;

  // receive side
  state_t          rx_state_q;
  logic [BW-1:0]   rx_baud_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q, rbr_q;
  logic            dr_q;

  // Synchronize the asynchronous strobes and serial input; idle level is 1
  always_ff @(posedge CLK) begin
    if (RST) begin
      {rdn_s1_q, rdn_s2_q, rdn_p_q} <= 3'b111;
      {wrn_s1_q, wrn_s2_q, wrn_p_q} <= 3'b111;
      {rxd_s1_q, rxd_s2_q, rxd_p_q} <= 3'b111;
    end else begin
      rdn_s1_q <= bus.rdn;  rdn_s2_q <= rdn_s1_q;  rdn_p_q <= rdn_s2_q;
      wrn_s1_q <= bus.wrn;  wrn_s2_q <= wrn_s1_q;  wrn_p_q <= wrn_s2_q;
      rxd_s1_q <= rxd;      rxd_s2_q <= rxd_s1_q;  rxd_p_q <= rxd_s2_q;
    end
  end

  assign rdn_rise = rdn_s2_q & ~rdn_p_q;
  assign wrn_rise = wrn_s2_q & ~wrn_p_q;
  assign rxd_fall = ~rxd_s2_q & rxd_p_q;
  assign tx_bit_d = tx_bit_q + 3'd1;

  // Bus write capture into THR and the transmit frame sequencer.
  // A write only lands when tbre=1 and a THR->TSR load only happens when
  // tbre=0, so the two never touch tbre in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      thr_q      <= '0;
      tsr_q      <= '0;
      wr_smp_q   <= '0;
      tbre_q     <= 1'b1;
      tsre_q     <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      if (!wrn_s2_q) wr_smp_q <= ram1Data;
      if (wrn_rise && tbre_q) begin
        thr_q  <= wr_smp_q;
        tbre_q <= 1'b0;
      end
      case (tx_state_q)
        S_IDLE: begin
          if (!tbre_q) begin
            tsr_q      <= thr_q;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b0;
            txd_q      <= 1'b0;
            tx_baud_q  <= '0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tsr_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_bit_q <= tx_bit_d;
              txd_q    <= tsr_q[tx_bit_d];
            end
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
        default: begin  // S_STOP
          if (tx_baud_q == BAUD_LAST) begin
            tx_baud_q <= '0;
            if (!tbre_q) begin
              // next byte already waiting: chain frames with no idle gap
              tsr_q      <= thr_q;
              tbre_q     <= 1'b1;
              txd_q      <= 1'b0;
              tx_state_q <= S_START;
            end else begin
              tsre_q     <= 1'b1;
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Receive frame sampler, RBR and data_ready; a completing frame takes
  // priority over a read clearing data_ready in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state_q <= S_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rbr_q      <= '0;
      dr_q       <= 1'b0;
    end else begin
      if (rdn_rise) dr_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          if (rxd_fall) begin
            rx_baud_q  <= '0;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          if (rx_baud_q == BAUD_HALF) begin
            rx_baud_q <= '0;
            rx_bit_q  <= '0;
            // line back high at mid-start means a glitch, not a frame
            rx_state_q <= rxd_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_baud_q == BAUD_LAST) begin
            rx_baud_q  <= '0;
            rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        default: begin  // S_STOP
          if (rx_baud_q == BAUD_LAST) begin
            rx_baud_q  <= '0;
            rx_state_q <= S_IDLE;
            // stop bit low is a framing error: drop the byte silently
            if (rxd_s2_q) begin
              rbr_q <= rx_shift_q;
              dr_q  <= 1'b1;
            end
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.tbre       = tbre_q;
  assign bus.tsre       = tsre_q;
  assign bus.data_ready = dr_q;
  assign txd            = txd_q;

  // raw rdn gates the drive so data is valid inside the strobe itself
  assign ram1Data = (!bus.rdn && !RST) ? rbr_q : 8'bz;

endmodule

// File: tb/tb_uart_port_responder.sv
// Directed bench for uart_port_responder at 16 clocks per bit.
module tb_uart_port_responder;
  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rxd = 1'b1;
  logic       txd;
  logic [7:0] bus_drv = 8'h00;
  logic       bus_en = 1'b0;
  tri1  [7:0] ram1Data;
  int         checks = 0;
  int         errors = 0;

  uart_port_responder_if bus_if();

  assign ram1Data = bus_en ? bus_drv : 8'bz;

  uart_port_responder #(.CLKS_PER_BIT(CPB)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus_if),
    .ram1Data (ram1Data),
    .txd      (txd),
    .rxd      (rxd)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [7:0] d);
    bus_drv = d;
    bus_en  = 1'b1;
    bus_if.wrn = 1'b0;
    repeat (4) @(negedge CLK);
    bus_if.wrn = 1'b1;
    repeat (3) @(negedge CLK);
    bus_en = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge CLK);
    end
    rxd = stop;
    repeat (CPB) @(negedge CLK);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    bus_if.rdn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (bus_if.tbre !== 1'b1) begin errors++; $display("FAIL reset_tbre got %b exp 1", bus_if.tbre); end
    checks++; if (bus_if.tsre !== 1'b1) begin errors++; $display("FAIL reset_tsre got %b exp 1", bus_if.tsre); end
    checks++; if (bus_if.data_ready !== 1'b0) begin errors++; $display("FAIL reset_dr got %b exp 0", bus_if.data_ready); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
    checks++; if (ram1Data !== 8'hFF) begin errors++; $display("FAIL reset_bus_z got %h exp ff(released)", ram1Data); end
    bus_if.rdn = 1'b1;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_tx_single;
    logic [9:0] exp = 10'b1101001010;  // start, A5 LSB first, stop
    do_write(8'hA5);
    checks++; if (bus_if.tbre !== 1'b0) begin errors++; $display("FAIL tx_tbre_low got %b exp 0", bus_if.tbre); end
    for (int i = 0; i < 60 && txd !== 1'b0; i++) @(negedge CLK);
    checks++;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL tx_start_timeout got txd %b exp 0", txd);
    end else begin
      checks++; if (bus_if.tbre !== 1'b1) begin errors++; $display("FAIL tx_tbre_reload got %b exp 1", bus_if.tbre); end
      checks++; if (bus_if.tsre !== 1'b0) begin errors++; $display("FAIL tx_tsre_busy got %b exp 0", bus_if.tsre); end
      repeat (CPB/2) @(negedge CLK);
      for (int i = 0; i < 10; i++) begin
        checks++; if (txd !== exp[i]) begin errors++; $display("FAIL tx_bit%0d got %b exp %b", i, txd, exp[i]); end
        if (i < 9) repeat (CPB) @(negedge CLK);
      end
      repeat (10) @(negedge CLK);
      checks++; if (bus_if.tsre !== 1'b1) begin errors++; $display("FAIL tx_tsre_done got %b exp 1", bus_if.tsre); end
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL tx_idle got %b exp 1", txd); end
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp = {1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 1'b0};
    logic        seen;
    seen = 1'b0;
    fork
      begin
        do_write(8'h01);
        repeat (2) @(negedge CLK);
        do_write(8'h80);
        repeat (2) @(negedge CLK);
        do_write(8'hFF);  // THR still full: must be dropped
      end
      begin
        for (int i = 0; i < 60 && txd !== 1'b0; i++) @(negedge CLK);
        checks++;
        if (txd !== 1'b0) begin
          errors++; $display("FAIL b2b_start_timeout got txd %b exp 0", txd);
        end else begin
          seen = 1'b1;
          repeat (CPB/2) @(negedge CLK);
          for (int i = 0; i < 20; i++) begin
            checks++; if (txd !== exp[i]) begin errors++; $display("FAIL b2b_bit%0d got %b exp %b", i, txd, exp[i]); end
            if (i == 9) begin
              checks++; if (bus_if.tsre !== 1'b0) begin errors++; $display("FAIL b2b_tsre_gap got %b exp 0", bus_if.tsre); end
            end
            if (i < 19) repeat (CPB) @(negedge CLK);
          end
        end
      end
    join
    if (seen) begin
      repeat (10) @(negedge CLK);
      checks++; if (bus_if.tsre !== 1'b1) begin errors++; $display("FAIL b2b_tsre_done got %b exp 1", bus_if.tsre); end
      checks++; if (bus_if.tbre !== 1'b1) begin errors++; $display("FAIL b2b_tbre_done got %b exp 1", bus_if.tbre); end
      for (int i = 0; i < 3; i++) begin
        repeat (CPB) @(negedge CLK);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL b2b_dropped_idle%0d got %b exp 1", i, txd); end
      end
    end
  endtask

  task automatic test_rx_read;
    checks++; if (bus_if.data_ready !== 1'b0) begin errors++; $display("FAIL rx_dr_pre got %b exp 0", bus_if.data_ready); end
    send_rx(8'h3C, 1'b1);
    checks++; if (bus_if.data_ready !== 1'b1) begin errors++; $display("FAIL rx_dr_set got %b exp 1", bus_if.data_ready); end
    bus_if.rdn = 1'b0;
    #1;
    checks++; if (ram1Data !== 8'h3C) begin errors++; $display("FAIL rx_bus_read got %h exp 3c", ram1Data); end
    repeat (4) @(negedge CLK);
    checks++; if (bus_if.data_ready !== 1'b1) begin errors++; $display("FAIL rx_dr_during_rd got %b exp 1", bus_if.data_ready); end
    bus_if.rdn = 1'b1;
    repeat (4) @(negedge CLK);
    checks++; if (bus_if.data_ready !== 1'b0) begin errors++; $display("FAIL rx_dr_clear got %b exp 0", bus_if.data_ready); end
    checks++; if (ram1Data !== 8'hFF) begin errors++; $display("FAIL rx_bus_release got %h exp ff(released)", ram1Data); end
  endtask

  task automatic test_rx_errors;
    rxd = 1'b0;
    repeat (4) @(negedge CLK);
    rxd = 1'b1;
    repeat (200) @(negedge CLK);
    checks++; if (bus_if.data_ready !== 1'b0) begin errors++; $display("FAIL rx_glitch_dr got %b exp 0", bus_if.data_ready); end
    send_rx(8'h5A, 1'b0);
    repeat (40) @(negedge CLK);
    checks++; if (bus_if.data_ready !== 1'b0) begin errors++; $display("FAIL rx_framing_dr got %b exp 0", bus_if.data_ready); end
    bus_if.rdn = 1'b0;
    #1;
    checks++; if (ram1Data !== 8'h3C) begin errors++; $display("FAIL rx_framing_rbr got %h exp 3c", ram1Data); end
    @(negedge CLK);
    bus_if.rdn = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_read_collision;
    send_rx(8'h11, 1'b1);
    checks++; if (bus_if.data_ready !== 1'b1) begin errors++; $display("FAIL col_first_dr got %b exp 1", bus_if.data_ready); end
    fork
      send_rx(8'h55, 1'b1);
      begin
        // synced rdn edge lands on the stop-bit sample cycle of this frame
        repeat (140) @(negedge CLK);
        bus_if.rdn = 1'b0;
        #1;
        checks++; if (ram1Data !== 8'h11) begin errors++; $display("FAIL col_old_byte got %h exp 11", ram1Data); end
        repeat (13) @(negedge CLK);
        bus_if.rdn = 1'b1;
      end
    join
    checks++; if (bus_if.data_ready !== 1'b1) begin errors++; $display("FAIL col_dr_kept got %b exp 1", bus_if.data_ready); end
    bus_if.rdn = 1'b0;
    #1;
    checks++; if (ram1Data !== 8'h55) begin errors++; $display("FAIL col_rbr got %h exp 55", ram1Data); end
    repeat (4) @(negedge CLK);
    bus_if.rdn = 1'b1;
    repeat (4) @(negedge CLK);
    checks++; if (bus_if.data_ready !== 1'b0) begin errors++; $display("FAIL col_dr_clear got %b exp 0", bus_if.data_ready); end
  endtask

  task automatic test_reset_mid_tx;
    logic went_low;
    do_write(8'h00);
    for (int i = 0; i < 60 && txd !== 1'b0; i++) @(negedge CLK);
    checks++;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL rst_start_timeout got txd %b exp 0", txd);
    end else begin
      repeat (CPB/2 + 4*CPB) @(negedge CLK);  // middle of data bit 3
      checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rst_bit3 got %b exp 0", txd); end
      checks++; if (bus_if.tsre !== 1'b0) begin errors++; $display("FAIL rst_tsre_busy got %b exp 0", bus_if.tsre); end
    end
    bus_if.rdn = 1'b0;
    #1;
    checks++; if (ram1Data !== 8'h55) begin errors++; $display("FAIL rst_bus_pre got %h exp 55", ram1Data); end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd got %b exp 1", txd); end
    checks++; if (bus_if.tbre !== 1'b1) begin errors++; $display("FAIL rst_tbre got %b exp 1", bus_if.tbre); end
    checks++; if (bus_if.tsre !== 1'b1) begin errors++; $display("FAIL rst_tsre got %b exp 1", bus_if.tsre); end
    checks++; if (ram1Data !== 8'hFF) begin errors++; $display("FAIL rst_bus_z got %h exp ff(released)", ram1Data); end
    RST = 1'b0;
    bus_if.rdn = 1'b1;
    went_low = 1'b0;
    for (int i = 0; i < 12*CPB; i++) begin
      @(negedge CLK);
      if (txd !== 1'b1) went_low = 1'b1;
    end
    checks++; if (went_low !== 1'b0) begin errors++; $display("FAIL rst_abandon got txd_low %b exp 0", went_low); end
  endtask

  initial begin
    bus_if.rdn = 1'b1;
    bus_if.wrn = 1'b1;
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_read();
    test_rx_errors();
    test_read_collision();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
